// File: rtl/ifft_8point_seq_if.sv
// Bundle of the request/result signals of the 8-point sequential IFFT.
// Handshake: start is taken only while busy=0; done pulses for one cycle when out_re/out_im become valid.
interface ifft_8point_seq_if #(
  parameter int DW = 16
);
  logic            start;
  logic [8*DW-1:0] in_re;
  logic [8*DW-1:0] in_im;
  logic [8*DW-1:0] out_re;
  logic [8*DW-1:0] out_im;
  logic            busy;
  logic            done;

  modport master (
    output start, in_re, in_im,
    input  out_re, out_im, busy, done
  );

  modport slave (
    input  start, in_re, in_im,
    output out_re, out_im, busy, done
  );
endinterface

// File: rtl/ifft_8point_seq.sv
// 8-point inverse FFT, iterative radix-2 DIT, one butterfly per clock.
// Each stage halves its results, so three stages give the 1/8 scaling.
module ifft_8point_seq #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic               clk,
  input  logic               rst,
  ifft_8point_seq_if.slave   bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [DW-1:0] TW_ONE  = DW'(256);
  localparam logic signed [DW-1:0] TW_R2   = DW'(181);
  localparam logic signed [DW-1:0] TW_NR2  = DW'(-181);
  localparam logic signed [DW-1:0] TW_ZERO = '0;

  state_t                state;
  logic [1:0]            stage;
  logic [1:0]            bfly;
  logic signed [DW-1:0]  rf_re [8];
  logic signed [DW-1:0]  rf_im [8];
  logic [8*DW-1:0]       out_re_q;
  logic [8*DW-1:0]       out_im_q;
  logic                  busy_q;
  logic                  done_q;

  logic [2:0]            a_idx;
  logic [2:0]            b_idx;
  logic [1:0]            tw_k;
  logic signed [DW-1:0]  tw_c;
  logic signed [DW-1:0]  tw_s;
  logic signed [DW-1:0]  a_re, a_im, b_re, b_im;
  logic signed [2*DW-1:0] p_rr, p_is, p_rs, p_ic;
  logic signed [2*DW:0]  m_re, m_im;
  logic signed [DW:0]    wb_re, wb_im;
  logic signed [DW+1:0]  sum_re, sum_im, dif_re, dif_im;
  logic                  capture;

  function automatic int bitrev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Stage s pairs entries span 2^s apart; twiddle index is (j mod 2^s) * 2^(2-s).
  always_comb begin
    a_idx = {1'b0, bfly};
    b_idx = {1'b1, bfly};
    tw_k  = bfly;
    case (stage)
      2'd0: begin
        a_idx = {bfly, 1'b0};
        b_idx = {bfly, 1'b1};
        tw_k  = 2'd0;
      end
      2'd1: begin
        a_idx = {bfly[1], 1'b0, bfly[0]};
        b_idx = {bfly[1], 1'b1, bfly[0]};
        tw_k  = {bfly[0], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    tw_c = TW_ONE;
    tw_s = TW_ZERO;
    case (tw_k)
      2'd1:    begin tw_c = TW_R2;   tw_s = TW_R2;  end
      2'd2:    begin tw_c = TW_ZERO; tw_s = TW_ONE; end
      2'd3:    begin tw_c = TW_NR2;  tw_s = TW_R2;  end
      default: ;
    endcase
  end

  assign a_re = rf_re[a_idx];
  assign a_im = rf_im[a_idx];
  assign b_re = rf_re[b_idx];
  assign b_im = rf_im[b_idx];

  assign p_rr = (2*DW)'(b_re) * (2*DW)'(tw_c);
  assign p_is = (2*DW)'(b_im) * (2*DW)'(tw_s);
  assign p_rs = (2*DW)'(b_re) * (2*DW)'(tw_s);
  assign p_ic = (2*DW)'(b_im) * (2*DW)'(tw_c);

  assign m_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_is);
  assign m_im = (2*DW+1)'(p_rs) + (2*DW+1)'(p_ic);

  // Floor shift back to Q8.8, keeping one guard bit above the sample width.
  assign wb_re = (DW+1)'(m_re >>> FRAC);
  assign wb_im = (DW+1)'(m_im >>> FRAC);

  assign sum_re = (DW+2)'(a_re) + (DW+2)'(wb_re);
  assign sum_im = (DW+2)'(a_im) + (DW+2)'(wb_im);
  assign dif_re = (DW+2)'(a_re) - (DW+2)'(wb_re);
  assign dif_im = (DW+2)'(a_im) - (DW+2)'(wb_im);

  assign capture = bus.start && ((state == IDLE) || (state == DONE));

  // stage==3 is the final CALC cycle that publishes the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      stage    <= 2'd0;
      bfly     <= 2'd0;
      out_re_q <= '0;
      out_im_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_re[i] <= '0;
        rf_im[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (capture) begin
        for (int i = 0; i < 8; i++) begin
          rf_re[i] <= bus.in_re[DW*bitrev3(i) +: DW];
          rf_im[i] <= bus.in_im[DW*bitrev3(i) +: DW];
        end
        stage  <= 2'd0;
        bfly   <= 2'd0;
        busy_q <= 1'b1;
        state  <= CALC;
      end else begin
        case (state)
          CALC: begin
            if (stage == 2'd3) begin
              for (int i = 0; i < 8; i++) begin
                out_re_q[DW*i +: DW] <= rf_re[i];
                out_im_q[DW*i +: DW] <= rf_im[i];
              end
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              rf_re[a_idx] <= DW'(sum_re >>> 1);
              rf_im[a_idx] <= DW'(sum_im >>> 1);
              rf_re[b_idx] <= DW'(dif_re >>> 1);
              rf_im[b_idx] <= DW'(dif_im >>> 1);
              if (bfly == 2'd3) begin
                bfly  <= 2'd0;
                stage <= stage + 2'd1;
              end else begin
                bfly <= bfly + 2'd1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_re = out_re_q;
  assign bus.out_im = out_im_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign state_dbg  = state;

endmodule
